// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default line settings and
// bit-timing helpers used by the receiver (and later the transmitter).
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    function automatic int unsigned bit_ticks(input int unsigned clk_freq,
                                              input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Reload value that lands the first sample in the middle of the start bit.
    function automatic int unsigned half_bit(input int unsigned ticks);
        return ticks / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// CPU-facing side of the UART receiver: received byte, status flags and the
// read-clear pulse coming back from the peripheral register decoder.
interface uart_rx_sequencer_if;

    logic       rx_clr_i;
    logic [7:0] rx_data_o;
    logic       rx_ready_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    modport master (
        output rx_clr_i,
        input  rx_data_o, rx_ready_o, parity_err_o, frame_err_o, overrun_o, busy_o
    );

    modport slave (
        input  rx_clr_i,
        output rx_data_o, rx_ready_o, parity_err_o, frame_err_o, overrun_o, busy_o
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Loadable down-counter that strobes 'sample' on the cycle it reads zero.
// It parks at zero until reloaded; shared between receive and transmit paths.
module uart_baud_counter #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             sample
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign sample = (count == '0);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive controller: synchronises the serial line, sequences
// start/data/parity/stop and hands each byte to the CPU with status flags.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    uart_rx_sequencer_if.slave   cpu
);

    localparam int unsigned     BIT_TICKS = bit_ticks(CLK_FREQ, BAUD);
    localparam int unsigned     CNT_W     = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(half_bit(BIT_TICKS));

    logic             rx_meta, rx_s;
    rx_state_e        state, state_next;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             sample;
    logic             commit;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_idx;
    logic             perr;

    logic [7:0]       data_q;
    logic             ready_q, parity_err_q, frame_err_q, overrun_q;

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    // NOTE: every clocked process uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_counter #(.WIDTH(CNT_W)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .sample   (sample)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s)  state_next = START;
            START:     if (sample) state_next = rx_s ? IDLE : DATA;
            DATA:      if (sample && bit_idx == 3'd7) state_next = PARITY_EN ? PARITY : STOP;
            PARITY:    if (sample) state_next = STOP;
            STOP:      if (sample) state_next = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s)   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: outputs of a combinational block get defaults first so no path infers a latch.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = FULL_LOAD;
        case (state)
            IDLE: if (!rx_s) begin
                cnt_load = 1'b1;
                cnt_val  = HALF_LOAD;
            end
            START:        cnt_load = sample && !rx_s;
            DATA, PARITY: cnt_load = sample;
            default:      cnt_load = 1'b0;
        endcase
    end

    assign commit = (state == STOP) && sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_idx   <= '0;
            perr      <= 1'b0;
        end else begin
            if (state == START && sample) bit_idx <= '0;
            if (state == DATA && sample) begin
                shift_reg[bit_idx] <= rx_s;
                bit_idx            <= bit_idx + 3'd1;
            end
            if (state == PARITY && sample) perr <= (^shift_reg) ^ rx_s ^ PARITY_ODD;
        end
    end

    // A commit beats a simultaneous clear; the clear still counts as reading the old byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q       <= '0;
            ready_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (commit) begin
            data_q       <= shift_reg;
            ready_q      <= 1'b1;
            parity_err_q <= PARITY_EN ? perr : 1'b0;
            frame_err_q  <= ~rx_s;
            overrun_q    <= cpu.rx_clr_i ? 1'b0 : (overrun_q | ready_q);
        end else if (cpu.rx_clr_i) begin
            ready_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign cpu.rx_data_o    = data_q;
    assign cpu.rx_ready_o   = ready_q;
    assign cpu.parity_err_o = parity_err_q;
    assign cpu.frame_err_o  = frame_err_q;
    assign cpu.overrun_o    = overrun_q;
    assign cpu.busy_o       = (state != IDLE);

endmodule

// File: doc/uart_rx_sequencer.md
Name: uart_rx_sequencer

Overview:
UART receive controller for the single-cycle RISC-V SoC's UART port. It samples the asynchronous serial line and sequences the frame: start, 8 data bits LSB-first, optional parity, and stop. It presents each received byte to the CPU's memory-mapped peripheral logic through a ready/clear handshake, with parity, framing and overrun status. It sits between the top-level UART_Rx pin and the peripheral register decoder.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
BIT_TICKS, CLK_FREQ/BAUD (434), clocks per bit; localparam, not overridden independently.
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous, active-low reset.
rx_i  input  1  serial line, asynchronous, idle high.
rx_clr_i  input  1  one-cycle pulse from CPU read; clears ready and all status flags.
rx_data_o  output  8  last committed byte.
rx_ready_o  output  1  byte available; held until cleared.
parity_err_o  output  1  parity mismatch on the committed byte.
frame_err_o  output  1  stop bit sampled low.
overrun_o  output  1  new byte committed while rx_ready_o was still set.
busy_o  output  1  FSM is not in IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Both synchronizer flops go to 1.
  - FSM goes to IDLE, counters go to 0.
  - All outputs go to 0, including rx_data_o = 8'h00.
  - Reset mid-frame abandons the partial frame; nothing is committed.
- Synchronizer: two flops; rx_s is the second flop. All decisions use rx_s only.
- Bit counter: width $clog2(BIT_TICKS). It loads a value, counts down, and the sample point is the cycle it reads 0.
- IDLE:
  - When rx_s = 0, load the counter with BIT_TICKS/2-1 (216) and go to START.
- START:
  - At the sample point, if rx_s = 0: load BIT_TICKS-1, set bit_idx = 0, go to DATA.
  - If rx_s = 1 (glitch): go to IDLE; no flags change.
- DATA:
  - At each sample point, shift rx_s into bit[bit_idx] and reload BIT_TICKS-1.
  - When bit_idx = 7, go to PARITY if PARITY_EN = 1, else to STOP.
  - bit_idx is 3 bits and never wraps inside a frame.
- PARITY:
  - Sample rx_s and compute perr = (^data) ^ rx_s ^ PARITY_ODD. perr = 1 means error.
  - Reload the counter and go to STOP.
- STOP: at the sample point, commit on the next clock edge:
  - rx_data_o <= shift register.
  - rx_ready_o <= 1.
  - parity_err_o <= perr, or 0 when PARITY_EN = 0.
  - frame_err_o <= ~rx_s.
  - overrun_o <= overrun_o | rx_ready_o.
  - Next state is IDLE if rx_s = 1, else WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break or low stop bit from being seen as a new start.
- Commit latency: outputs update 1 clock after the stop-bit sample point. The sample point is about 2 sync clocks + 216 + 9×434 clocks (10×434 with parity) after rx_i falls.
- rx_clr_i with no commit in the same cycle: on the next edge, rx_ready_o, parity_err_o, frame_err_o and overrun_o go to 0. rx_data_o is unchanged.
- rx_clr_i in the same cycle as a commit: the commit wins.
  - rx_ready_o = 1 with the new status flags.
  - overrun_o = 0, because the previous byte is considered read.
- rx_clr_i has no effect on the FSM.
- busy_o = 1 in START, DATA, PARITY, STOP and WAIT_HIGH.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Default CLK_FREQ and BAUD constants.
  - Function computing BIT_TICKS and the half-bit value.
- One sub-module, uart_baud_counter: a loadable down-counter with a sample strobe. It is reusable by the future transmitter.
- Synchronizer and FSM are inline.

Test Plan:
1. Frame 0x0C with parity bit 0, 8680 ns per bit, even parity -> rx_ready_o = 1, rx_data_o = 8'h0C, parity_err_o = 0, frame_err_o = 0, overrun_o = 0.
2. Frame 0x08 with parity bit 0, even parity -> rx_data_o = 8'h08, parity_err_o = 1, rx_ready_o = 1. Pulse rx_clr_i -> all flags 0 next cycle, data stays 8'h08.
3. rx_i low for 100 clocks, then high -> busy_o rises then falls in the START check; rx_ready_o stays 0 and the FSM returns to IDLE.
4. Frame 0x55 with stop bit 0 and the line held low for 2 bit times -> frame_err_o = 1, rx_data_o = 8'h55. busy_o stays 1 until the line returns high, and no extra frame is received.
5. Frames 0x0C then 0xAA with no clear between -> rx_data_o = 8'hAA, overrun_o = 1. Repeat with rx_clr_i pulsed exactly in the second commit cycle -> overrun_o = 0, rx_ready_o = 1.
6. Assert rst during data bit 4 of a frame -> all outputs 0 immediately. The following full frame 0x0C is received correctly.
